cpu_control_sequencer: RTL and testbench

- Moore-style control unit that sequences the Mini SRC datapath through fetch and execute.
- Drives every datapath load enable, the bus select, the GP register address, ALU_op, incPC and MDR_read.
- Decodes the IR value returned from the datapath.
- Replaces hand-written testbench stimulus and is the top-level controller between memory and the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 70 +++++++
 rtl/cpu_control_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer.
//   - opcode constants (ir[31:27])
//   - BusDataSelect source encodings
//   - sequencer state enum and opcode class decode helper
package cpu_ctrl_pkg;

  // Opcodes
  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpAnd  = 5'd2;
  localparam logic [4:0] OpOr   = 5'd3;
  localparam logic [4:0] OpShr  = 5'd4;
  localparam logic [4:0] OpShl  = 5'd5;
  localparam logic [4:0] OpRor  = 5'd6;
  localparam logic [4:0] OpRol  = 5'd7;
  localparam logic [4:0] OpMul  = 5'd8;
  localparam logic [4:0] OpDiv  = 5'd9;
  localparam logic [4:0] OpNot  = 5'd10;
  localparam logic [4:0] OpNeg  = 5'd11;
  localparam logic [4:0] OpNop  = 5'd12;
  localparam logic [4:0] OpHalt = 5'd13;

  // Bus sources; R0-R15 are encoded as the register index itself.
  localparam logic [4:0] BusHi     = 5'd16;
  localparam logic [4:0] BusLo     = 5'd17;
  localparam logic [4:0] BusZhi    = 5'd18;
  localparam logic [4:0] BusZlo    = 5'd19;
  localparam logic [4:0] BusPc     = 5'd20;
  localparam logic [4:0] BusMdr    = 5'd21;
  localparam logic [4:0] BusInport = 5'd22;
  localparam logic [4:0] BusCsign  = 5'd23;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalted
  } state_e;

  typedef enum logic [2:0] {
    ClsBinary,
    ClsUnary,
    ClsMulDiv,
    ClsNop,
    ClsHalt,
    ClsUndef
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    if (op <= OpRol) begin
      cls = ClsBinary;
    end else begin
      case (op)
        OpMul, OpDiv: cls = ClsMulDiv;
        OpNot, OpNeg: cls = ClsUnary;
        OpNop:        cls = ClsNop;
        OpHalt:       cls = ClsHalt;
        default:      cls = ClsUndef;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/cpu_control_sequencer.sv
// Moore control unit sequencing the Mini SRC datapath through fetch (T0-T2) and
// execute (T3-T6). All control outputs are decoded from the state register plus
// IR fields, so each state yields a one-cycle pulse of its controls.
//
// Ports:
//   clock, clear       - rising-edge clock, synchronous active-high reset
//   run                - permits starting/continuing instruction fetch
//   ir[31:0]           - current IR contents from the datapath
//   mem_ready          - memory read data valid on Mdatain
//   e_PC..e_GP         - datapath register load enables
//   incPC, MDR_read    - PC increment, MDR mux selects Mdatain
//   ALU_op[3:0]        - ALU operation (opcode[3:0] during execute)
//   BusDataSelect[4:0] - bus source, GP_addr[3:0] - GP register index
//   halted, illegal    - sticky status flags
//
// Parameter MEM_WAIT_MAX: T1 cycles waited for mem_ready before forcing the MDR
// load (0 = wait forever).
// Build option: define ILLEGAL_TRAP_EN to trap undefined opcodes (sets illegal and
// halts); otherwise they behave as NOP and illegal is tied low.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic        halted,
  output logic        illegal
);

  localparam int unsigned CntW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            halted_q, halted_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  op_class_e  cls;
  logic       mem_timeout;
  state_e     next_fetch;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[14:0];

  assign mem_timeout = (MEM_WAIT_MAX != 0) && (wait_cnt_q == CntW'(MEM_WAIT_MAX));
  // Where to go once an instruction completes; run is only sampled here and in IDLE.
  assign next_fetch  = run ? StT0 : StIdle;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    halted_d      = halted_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d     = illegal_q;
`endif
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    ALU_op        = 4'd0;
    BusDataSelect = 5'd0;
    GP_addr       = 4'd0;

    case (state_q)
      StIdle: begin
        if (run) state_d = StT0;
      end

      StT0: begin
        BusDataSelect = BusPc;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        state_d       = StT1;
      end

      StT1: begin
        MDR_read = 1'b1;
        if (mem_ready || mem_timeout) begin
          e_MDR   = 1'b1;
          state_d = StT2;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // The opcode decision is taken here, so the datapath must present the
      // incoming instruction on ir while it is being loaded.
      StT2: begin
        BusDataSelect = BusMdr;
        e_IR          = 1'b1;
        case (cls)
          ClsHalt: begin
            state_d  = StHalted;
            halted_d = 1'b1;
          end
          ClsNop: state_d = next_fetch;
          ClsUndef: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = StHalted;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
`else
            state_d   = next_fetch;
`endif
          end
          default: state_d = StT3;
        endcase
      end

      StT3: begin
        ALU_op  = opcode[3:0];
        state_d = StT4;
        case (cls)
          ClsBinary: begin
            BusDataSelect = {1'b0, rb};
            GP_addr       = rb;
            e_Y           = 1'b1;
          end
          ClsUnary: begin
            BusDataSelect = {1'b0, rb};
            GP_addr       = rb;
            e_Z           = 1'b1;
          end
          ClsMulDiv: begin
            BusDataSelect = {1'b0, ra};
            GP_addr       = ra;
            e_Y           = 1'b1;
          end
          default: state_d = next_fetch;
        endcase
      end

      StT4: begin
        ALU_op = opcode[3:0];
        case (cls)
          ClsBinary: begin
            BusDataSelect = {1'b0, rc};
            GP_addr       = rc;
            e_Z           = 1'b1;
            state_d       = StT5;
          end
          ClsUnary: begin
            BusDataSelect = BusZlo;
            GP_addr       = ra;
            e_GP          = 1'b1;
            state_d       = next_fetch;
          end
          ClsMulDiv: begin
            BusDataSelect = {1'b0, rb};
            GP_addr       = rb;
            e_Z           = 1'b1;
            state_d       = StT5;
          end
          default: state_d = next_fetch;
        endcase
      end

      StT5: begin
        ALU_op  = opcode[3:0];
        state_d = next_fetch;
        case (cls)
          ClsBinary: begin
            BusDataSelect = BusZlo;
            GP_addr       = ra;
            e_GP          = 1'b1;
          end
          ClsMulDiv: begin
            BusDataSelect = BusZlo;
            e_LO          = 1'b1;
            state_d       = StT6;
          end
          default: ;
        endcase
      end

      StT6: begin
        ALU_op        = opcode[3:0];
        BusDataSelect = BusZhi;
        e_HI          = 1'b1;
        state_d       = next_fetch;
      end

      StHalted: state_d = StHalted;

      default: state_d = StIdle;
    endcase
  end

  assign halted = halted_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_sequencer.sv
module tb_cpu_control_sequencer;

  localparam int unsigned WaitMax = 15;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        incPC, MDR_read, halted, illegal;
  logic [3:0]  ALU_op, GP_addr;
  logic [4:0]  BusDataSelect;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cpu_control_sequencer #(.MEM_WAIT_MAX(WaitMax)) dut (
    .clock        (clock),
    .clear        (clear),
    .run          (run),
    .ir           (ir),
    .mem_ready    (mem_ready),
    .e_PC         (e_PC),
    .e_IR         (e_IR),
    .e_Y          (e_Y),
    .e_Z          (e_Z),
    .e_HI         (e_HI),
    .e_LO         (e_LO),
    .e_MDR        (e_MDR),
    .e_MAR        (e_MAR),
    .e_GP         (e_GP),
    .incPC        (incPC),
    .MDR_read     (MDR_read),
    .ALU_op       (ALU_op),
    .BusDataSelect(BusDataSelect),
    .GP_addr      (GP_addr),
    .halted       (halted),
    .illegal      (illegal)
  );

  typedef struct packed {
    logic [8:0] en;  // PC IR Y Z HI LO MDR MAR GP
    logic       inc;
    logic       rd;
    logic [3:0] alu;
    logic [4:0] bus;
    logic [3:0] gp;
    logic       hlt;
    logic       ill;
  } out_t;

  typedef struct {
    logic        clr;
    logic        run;
    logic        rdy;
    logic [31:0] ir;
    out_t        exp;
  } vec_t;

  localparam logic [8:0] EnNone = 9'h000, EnIr = 9'h080, EnY = 9'h040, EnZ = 9'h020;
  localparam logic [8:0] EnHi = 9'h010, EnLo = 9'h008, EnMdr = 9'h004, EnMar = 9'h002;
  localparam logic [8:0] EnGp = 9'h001;

  vec_t q[$];

  function automatic out_t mk(input logic [8:0] en, input logic inc, input logic rd,
                              input logic [3:0] alu, input logic [4:0] bus,
                              input logic [3:0] gp, input logic hlt, input logic ill);
    out_t o;
    o = '{en: en, inc: inc, rd: rd, alu: alu, bus: bus, gp: gp, hlt: hlt, ill: ill};
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o = {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read, ALU_op,
         BusDataSelect, GP_addr, halted, illegal};
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = dut_out();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got en=%b inc=%b rd=%b alu=%0d bus=%0d gp=%0d h=%b i=%b, want en=%b inc=%b rd=%b alu=%0d bus=%0d gp=%0d h=%b i=%b",
               name, got.en, got.inc, got.rd, got.alu, got.bus, got.gp, got.hlt, got.ill,
               exp.en, exp.inc, exp.rd, exp.alu, exp.bus, exp.gp, exp.hlt, exp.ill);
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance one cycle.
  task automatic apply(input vec_t v, input string name);
    clear     = v.clr;
    run       = v.run;
    mem_ready = v.rdy;
    ir        = v.ir;
    @(negedge clock);
    check(name, v.exp);
    @(posedge clock);
    #1;
  endtask

  task automatic play(input string name);
    vec_t v;
    int   k;
    k = 0;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply(v, $sformatf("%s[%0d]", name, k));
      k++;
    end
  endtask

  task automatic push(input logic clr, input logic r, input logic rdy, input logic [31:0] irv,
                      input out_t exp);
    vec_t v;
    v = '{clr: clr, run: r, rdy: rdy, ir: irv, exp: exp};
    q.push_back(v);
  endtask

  function automatic logic rb1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: expands one instruction into its expected per-cycle trace.
  // w = cycles mem_ready stays low in T1; run_end = run during the final cycle.
  task automatic build(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input int unsigned w, input logic run_end,
                       input logic [14:0] low);
    logic [31:0] irv;
    logic [3:0]  a;
    int unsigned nlow;
    bit          stops;
    int          nidle;
    irv   = {op, ra, rb, rc, low};
    a     = op[3:0];
    nlow  = (w > WaitMax) ? WaitMax : w;
    stops = 1'b0;
    push(0, rb1(), rb1(), irv, mk(EnMar, 1, 0, 0, 5'd20, 0, 0, 0));
    for (int i = 0; i < int'(nlow); i++) push(0, rb1(), 0, irv, mk(EnNone, 0, 1, 0, 0, 0, 0, 0));
    push(0, rb1(), (w <= WaitMax), irv, mk(EnMdr, 0, 1, 0, 0, 0, 0, 0));
    push(0, rb1(), rb1(), irv, mk(EnIr, 0, 0, 0, 5'd21, 0, 0, 0));
    if (op <= 7) begin
      push(0, rb1(), rb1(), irv, mk(EnY, 0, 0, a, {1'b0, rb}, rb, 0, 0));
      push(0, rb1(), rb1(), irv, mk(EnZ, 0, 0, a, {1'b0, rc}, rc, 0, 0));
      push(0, rb1(), rb1(), irv, mk(EnGp, 0, 0, a, 5'd19, ra, 0, 0));
    end else if (op == 8 || op == 9) begin
      push(0, rb1(), rb1(), irv, mk(EnY, 0, 0, a, {1'b0, ra}, ra, 0, 0));
      push(0, rb1(), rb1(), irv, mk(EnZ, 0, 0, a, {1'b0, rb}, rb, 0, 0));
      push(0, rb1(), rb1(), irv, mk(EnLo, 0, 0, a, 5'd19, 0, 0, 0));
      push(0, rb1(), rb1(), irv, mk(EnHi, 0, 0, a, 5'd18, 0, 0, 0));
    end else if (op == 10 || op == 11) begin
      push(0, rb1(), rb1(), irv, mk(EnZ, 0, 0, a, {1'b0, rb}, rb, 0, 0));
      push(0, rb1(), rb1(), irv, mk(EnGp, 0, 0, a, 5'd19, ra, 0, 0));
    end else if (op == 13) begin
      stops = 1'b1;
      for (int i = 0; i < 4; i++) push(0, rb1(), rb1(), irv, mk(EnNone, 0, 0, 0, 0, 0, 1, 0));
    end else if (op >= 14) begin
`ifdef ILLEGAL_TRAP_EN
      stops = 1'b1;
      for (int i = 0; i < 4; i++) push(0, rb1(), rb1(), irv, mk(EnNone, 0, 0, 0, 0, 0, 1, 1));
`endif
    end
    if (!stops) begin
      q[q.size()-1].run = run_end;
      if (!run_end) begin
        nidle = int'($urandom_range(1, 3));
        for (int i = 0; i < nidle; i++) push(0, (i == nidle - 1), rb1(), irv, '0);
      end
    end
  endtask

  localparam logic [31:0] IrAdd = 32'h0189_0000;  // ADD Ra=3 Rb=1 Rc=2
  localparam logic [31:0] IrNop = 32'h6000_0000;

  vec_t tbl[11];
  int   base;
  vec_t v;
  logic [4:0] op;
  int unsigned w;

  initial begin
    tbl[0]  = '{0, 1, 0, IrAdd, mk(EnNone, 0, 0, 0, 0, 0, 0, 0)};     // IDLE
    tbl[1]  = '{0, 1, 0, IrAdd, mk(EnMar, 1, 0, 0, 5'd20, 0, 0, 0)};  // T0
    tbl[2]  = '{0, 1, 1, IrAdd, mk(EnMdr, 0, 1, 0, 0, 0, 0, 0)};      // T1
    tbl[3]  = '{0, 1, 0, IrAdd, mk(EnIr, 0, 0, 0, 5'd21, 0, 0, 0)};   // T2
    tbl[4]  = '{0, 0, 0, IrAdd, mk(EnY, 0, 0, 0, 5'd1, 1, 0, 0)};     // T3
    tbl[5]  = '{0, 0, 0, IrAdd, mk(EnZ, 0, 0, 0, 5'd2, 2, 0, 0)};     // T4
    tbl[6]  = '{0, 1, 0, IrAdd, mk(EnGp, 0, 0, 0, 5'd19, 3, 0, 0)};   // T5
    tbl[7]  = '{0, 0, 0, IrNop, mk(EnMar, 1, 0, 0, 5'd20, 0, 0, 0)};  // T0
    tbl[8]  = '{0, 0, 1, IrNop, mk(EnMdr, 0, 1, 0, 0, 0, 0, 0)};      // T1
    tbl[9]  = '{0, 0, 0, IrNop, mk(EnIr, 0, 0, 0, 5'd21, 0, 0, 0)};   // T2, NOP done
    tbl[10] = '{0, 0, 1, IrNop, mk(EnNone, 0, 0, 0, 0, 0, 0, 0)};     // IDLE

    clear = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = IrAdd;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset", '0);

    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Directed instructions through the reference model.
    push(0, 1, 0, 0, '0);
    build(5'd11, 4'd4, 4'd0, 4'd0, 0, 1, 15'd0);   // NEG, ir = 0x5A000000
    build(5'd8, 4'd5, 4'd6, 4'd7, 0, 1, 15'd0);    // MUL
    build(5'd0, 4'd3, 4'd1, 4'd2, 4, 1, 15'd0);    // 4-cycle memory wait
    build(5'd1, 4'd9, 4'd8, 4'd7, 40, 1, 15'd0);   // mem_ready never: forced
    build(5'd2, 4'd1, 4'd2, 4'd3, 15, 0, 15'd0);   // ready coincides with timeout
    build(5'd20, 4'd1, 4'd2, 4'd3, 0, 1, 15'd0);   // undefined opcode
    build(5'd13, 4'd0, 4'd0, 4'd0, 1, 1, 15'd0);   // HALT
    play("directed");

    v = '{1, 1, 1, IrNop, mk(EnNone, 0, 0, 0, 0, 0, 1, 0)};
    apply(v, "halt_clear");
    v = '{0, 0, 1, IrNop, '0};
    apply(v, "after_clear");

    // clear during T4 of ADD aborts to IDLE with all outputs low.
    push(0, 1, 0, 0, '0);
    base = q.size();
    build(5'd0, 4'd3, 4'd1, 4'd2, 0, 1, 15'd0);
    while (q.size() > base + 5) void'(q.pop_back());
    q[base+4].clr = 1'b1;
    push(0, 0, 1, IrAdd, '0);
    push(0, 0, 1, IrAdd, '0);
    play("clr_t4");

`ifdef ILLEGAL_TRAP_EN
    push(0, 1, 0, 0, '0);
    build(5'd20, 4'd0, 4'd0, 4'd0, 2, 1, 15'd0);
    play("illegal");
    v = '{1, 0, 0, 0, mk(EnNone, 0, 0, 0, 0, 0, 1, 1)};
    apply(v, "illegal_clear");
    v = '{0, 0, 0, 0, '0};
    apply(v, "illegal_after_clear");
`endif

    // Randomized instruction stream.
    push(0, 1, 0, 0, '0);
    for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_TRAP_EN
      op = 5'($urandom_range(0, 12));
`else
      op = 5'($urandom_range(0, 31));
      if (op == 5'd13) op = 5'd12;
`endif
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
      build(op, 4'($urandom), 4'($urandom), 4'($urandom), w, rb1(), 15'($urandom));
      play($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
